ga_pop_eval: RTL and testbench
==============================

GA_POP_EVAL -- requirements
Module: ga_pop_eval

Interface
REQ-001 Parameter INPUT_WIDTH, default 8, SHALL set the chromosome width in bits.
REQ-002 Parameter POP_SIZE, default 8, SHALL set the population size; it must be a power of two and at least 2.
REQ-003 Derived FIT_W = (INPUT_WIDTH+1)*3 and IDX_W = clog2(POP_SIZE) SHALL size the fitness and index ports.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-006 start  in  1  SHALL request one evaluation pass; sampled only while idle.
REQ-007 busy  out  1  SHALL be high while a pass is in progress.
REQ-008 done  out  1  SHALL be a one-cycle pulse marking pass completion.
REQ-009 pop_wr_en  in  1  SHALL be the write strobe for the population store.
REQ-010 pop_wr_addr  in  IDX_W  SHALL be the population write index.
REQ-011 pop_wr_data  in  INPUT_WIDTH  SHALL be the chromosome to write.
REQ-012 ff_chrom  out  INPUT_WIDTH  SHALL be the chromosome driven to the fitness unit, registered.
REQ-013 ff_enable  out  1  SHALL be the fitness-unit enable, registered.
REQ-014 ff_fitness  in  FIT_W  SHALL be the unsigned fitness returned by the fitness unit (1-cycle registered latency).
REQ-015 best_chrom  out  INPUT_WIDTH  SHALL be the chromosome with the highest fitness of the last pass.
REQ-016 best_fitness  out  FIT_W  SHALL be that highest fitness.
REQ-017 best_idx  out  IDX_W  SHALL be that chromosome's population index.

Function
REQ-018 The block SHALL hold POP_SIZE x INPUT_WIDTH population registers, written at the clock edge when pop_wr_en=1, busy=0 and start=0; writes are otherwise dropped.
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and DRAIN. IDLE->ISSUE on start=1; ISSUE->DRAIN after index POP_SIZE-1 is issued; DRAIN->IDLE once the last fitness value is sampled.
REQ-020 With E0 the edge at which start is sampled in IDLE, ff_enable=1 and ff_chrom=pop[k] SHALL be driven in the cycle following edge E0+k, for k=0..POP_SIZE-1.
REQ-021 ff_enable SHALL be 0 in every other cycle; ff_chrom SHALL hold its last value while ff_enable=0.
REQ-022 The fitness for index k SHALL be sampled from ff_fitness at edge E0+k+2.
REQ-023 At edge E0+2 (k=0), best_fitness, best_chrom and best_idx SHALL be loaded unconditionally.
REQ-024 For k>0, best_* SHALL update only if ff_fitness > best_fitness (unsigned, full FIT_W), so a tie keeps the lowest index.
REQ-025 busy SHALL go high from edge E0 and low at edge E0+POP_SIZE+1; done SHALL be high for exactly the cycle following edge E0+POP_SIZE+1.
REQ-026 best_* SHALL hold between passes and SHALL stay unchanged from E0 until edge E0+2.
REQ-027 start SHALL be ignored while busy=1; start during the done cycle SHALL be accepted because the FSM is then in IDLE.
REQ-028 The population SHALL be read live during ISSUE; because writes are blocked while busy, each pass sees a consistent snapshot.

Reset
REQ-029 On rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, ff_enable, ff_chrom, best_chrom, best_fitness, best_idx and all population entries SHALL be 0.
REQ-030 rst SHALL take priority over start and pop_wr_en.
REQ-031 rst asserted mid-pass SHALL abort the pass with no done pulse; best_* SHALL read 0 afterwards.

Verification
REQ-032 Setup for all scenarios: POP_SIZE=8, INPUT_WIDTH=8, and a bench fitness stub that registers ff_fitness <= 3*ff_chrom when ff_enable=1.
REQ-033 Scenario 1: load pop = {5,9,200,7,200,1,0,3} and pulse start -> ff_enable high 8 consecutive cycles with chrom in that order; done 9 cycles after E0; best_chrom=200, best_fitness=600, best_idx=2 (tie resolved to the lower index).
REQ-034 Scenario 2: all entries 0 -> done pulses; best_fitness=0, best_idx=0.
REQ-035 Scenario 3: start re-asserted each cycle during a pass, and pop_wr_en writing addr 0 with 255 mid-pass -> no second pass begins, pop[0] is unchanged and the result matches scenario 1; start held through the done cycle launches a second pass immediately.
REQ-036 Scenario 4: rst asserted at edge E0+4 -> busy=0, ff_enable=0, no done pulse, all outputs 0 on the next cycle; a subsequent start on the zeroed population yields best_fitness=0.
REQ-037 Scenario 5: highest value 255 placed at index 7 -> best_idx=7, best_fitness=765, sampled at the last edge, proving the final sample is not lost.

Source files
------------

// File: rtl/ga_pop_eval_if.sv
// ga_pop_eval_if: control, population-write, fitness-unit and result signals of ga_pop_eval
interface ga_pop_eval_if #(
  parameter int INPUT_WIDTH = 8,
  parameter int POP_SIZE = 8
);
  localparam int FIT_W = (INPUT_WIDTH + 1) * 3;
  localparam int IDX_W = $clog2(POP_SIZE);
  logic start;
  logic busy;
  logic done;
  logic pop_wr_en;
  logic [IDX_W-1:0] pop_wr_addr;
  logic [INPUT_WIDTH-1:0] pop_wr_data;
  logic [INPUT_WIDTH-1:0] ff_chrom;
  logic ff_enable;
  logic [FIT_W-1:0] ff_fitness;
  logic [INPUT_WIDTH-1:0] best_chrom;
  logic [FIT_W-1:0] best_fitness;
  logic [IDX_W-1:0] best_idx;
  modport master (
    output start, pop_wr_en, pop_wr_addr, pop_wr_data, ff_fitness,
    input busy, done, ff_chrom, ff_enable, best_chrom, best_fitness, best_idx
  );
  modport slave (
    input start, pop_wr_en, pop_wr_addr, pop_wr_data, ff_fitness,
    output busy, done, ff_chrom, ff_enable, best_chrom, best_fitness, best_idx
  );
endinterface

// File: rtl/ga_pop_eval.sv
// ga_pop_eval: streams the population through an external fitness unit and keeps the fittest member
module ga_pop_eval #(
  parameter int INPUT_WIDTH = 8,
  parameter int POP_SIZE = 8
) (
  input logic clk,
  input logic rst,
  ga_pop_eval_if.slave bus
);
  localparam int FIT_W = (INPUT_WIDTH + 1) * 3;
  localparam int IDX_W = $clog2(POP_SIZE);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;
  logic [INPUT_WIDTH-1:0] pop [POP_SIZE];
  logic [IDX_W-1:0] icnt, scnt, issue_idx, best_idx;
  logic [INPUT_WIDTH-1:0] ff_chrom, best_chrom;
  logic [FIT_W-1:0] best_fitness;
  logic ff_enable, vld, done, issue, last_issue, last_sample;
  assign issue = (state == IDLE && bus.start) || state == ISSUE;
  assign issue_idx = state == ISSUE ? icnt : '0;
  assign last_issue = &icnt;
  assign last_sample = vld && &scnt;
  always_comb begin
    state_nx = (state == IDLE && bus.start) ? ISSUE :
               (state == ISSUE && last_issue) ? DRAIN :
               (state == DRAIN && last_sample) ? IDLE : state;
  end
  // vld marks the cycle in which ff_fitness carries the result for index scnt
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      icnt <= '0;
      scnt <= '0;
      vld <= 1'b0;
      done <= 1'b0;
      ff_enable <= 1'b0;
      ff_chrom <= '0;
      best_chrom <= '0;
      best_fitness <= '0;
      best_idx <= '0;
      for (int i = 0; i < POP_SIZE; i++) pop[i] <= '0;
    end else begin
      state <= state_nx;
      ff_enable <= issue;
      if (issue) ff_chrom <= pop[issue_idx];
      icnt <= issue ? issue_idx + 1'b1 : '0;
      vld <= ff_enable;
      if (vld) scnt <= scnt + 1'b1;
      done <= state == DRAIN && last_sample;
      if (vld && (scnt == '0 || bus.ff_fitness > best_fitness)) begin
        best_fitness <= bus.ff_fitness;
        best_chrom <= pop[scnt];
        best_idx <= scnt;
      end
      if (bus.pop_wr_en && state == IDLE && !bus.start) pop[bus.pop_wr_addr] <= bus.pop_wr_data;
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.ff_enable = ff_enable;
  assign bus.ff_chrom = ff_chrom;
  assign bus.best_chrom = best_chrom;
  assign bus.best_fitness = best_fitness;
  assign bus.best_idx = best_idx;
endmodule

// File: tb/tb_ga_pop_eval.sv
// tb_ga_pop_eval: directed vector table plus hand-written start/write/reset corner sequences
module tb_ga_pop_eval;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ga_pop_eval_if #(.INPUT_WIDTH(8), .POP_SIZE(8)) bus();
  ga_pop_eval #(.INPUT_WIDTH(8), .POP_SIZE(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always_ff @(posedge clk) if (bus.ff_enable) bus.ff_fitness <= 27'(bus.ff_chrom) * 27'd3;
  typedef struct {
    logic [0:7][7:0] pop;
    logic [7:0] ec;
    logic [26:0] ef;
    logic [2:0] ei;
  } vec_t;
  vec_t vt [6];
  int total = 0;
  int bad = 0;
  logic [7:0] pc;
  logic [26:0] pf;
  logic [2:0] pi;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic chk_best(input logic [7:0] c, input logic [26:0] f, input logic [2:0] i);
    chk("best_chrom", 32'(bus.best_chrom), 32'(c));
    chk("best_fitness", 32'(bus.best_fitness), 32'(f));
    chk("best_idx", 32'(bus.best_idx), 32'(i));
  endtask
  task automatic load(input logic [0:7][7:0] p);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.pop_wr_en = 1'b1;
      bus.pop_wr_addr = 3'(i);
      bus.pop_wr_data = p[i];
    end
    @(negedge clk);
    bus.pop_wr_en = 1'b0;
  endtask
  task automatic run_pass(input vec_t v);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("ff_enable", 32'(bus.ff_enable), 32'(c <= 7));
      chk("ff_chrom", 32'(bus.ff_chrom), 32'(v.pop[c <= 7 ? c : 7]));
      chk("busy", 32'(bus.busy), 32'(c <= 8));
      chk("done", 32'(bus.done), 32'(c == 9));
      if (c <= 1) chk_best(pc, pf, pi);
    end
    chk_best(v.ec, v.ef, v.ei);
    pc = v.ec;
    pf = v.ef;
    pi = v.ei;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pop_wr_en = 1'b0;
    bus.pop_wr_addr = '0;
    bus.pop_wr_data = '0;
    pc = '0;
    pf = '0;
    pi = '0;
    vt[0] = '{'{8'd5, 8'd9, 8'd200, 8'd7, 8'd200, 8'd1, 8'd0, 8'd3}, 8'd200, 27'd600, 3'd2};
    vt[1] = '{'{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd0, 27'd0, 3'd0};
    vt[2] = '{'{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd255}, 8'd255, 27'd765, 3'd7};
    vt[3] = '{'{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 27'd30, 3'd0};
    vt[4] = '{'{8'd255, 8'd254, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255}, 8'd255, 27'd765, 3'd0};
    vt[5] = '{'{8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0}, 8'd9, 27'd27, 3'd4};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ff_enable", 32'(bus.ff_enable), 32'd0);
    chk("rst_ff_chrom", 32'(bus.ff_chrom), 32'd0);
    chk_best(8'd0, 27'd0, 3'd0);
    bus.start = 1'b1;
    bus.pop_wr_en = 1'b1;
    @(negedge clk);
    chk("rst_priority_busy", 32'(bus.busy), 32'd0);
    chk("rst_priority_ff_enable", 32'(bus.ff_enable), 32'd0);
    bus.start = 1'b0;
    bus.pop_wr_en = 1'b0;
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      load(vt[v].pop);
      run_pass(vt[v]);
    end
    load(vt[0].pop);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      bus.pop_wr_en = c <= 8;
      bus.pop_wr_addr = 3'd0;
      bus.pop_wr_data = 8'd255;
      chk("s3_ff_enable", 32'(bus.ff_enable), 32'(c <= 7));
      chk("s3_ff_chrom", 32'(bus.ff_chrom), 32'(vt[0].pop[c <= 7 ? c : 7]));
      chk("s3_done", 32'(bus.done), 32'(c == 9));
    end
    chk_best(vt[0].ec, vt[0].ef, vt[0].ei);
    @(negedge clk);
    bus.start = 1'b0;
    chk("s3_relaunch_busy", 32'(bus.busy), 32'd1);
    chk("s3_relaunch_ff_enable", 32'(bus.ff_enable), 32'd1);
    chk("s3_pop0_kept", 32'(bus.ff_chrom), 32'd5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("s3_second_done", 32'(bus.done), 32'(c == 9));
    end
    chk_best(vt[0].ec, vt[0].ef, vt[0].ei);
    load(vt[0].pop);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s4_busy", 32'(bus.busy), 32'd0);
    chk("s4_ff_enable", 32'(bus.ff_enable), 32'd0);
    chk("s4_ff_chrom", 32'(bus.ff_chrom), 32'd0);
    chk("s4_done", 32'(bus.done), 32'd0);
    chk_best(8'd0, 27'd0, 3'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("s4_no_done", 32'(bus.done), 32'd0);
    end
    pc = '0;
    pf = '0;
    pi = '0;
    run_pass(vt[1]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
